// File: rtl/jt900h_intc_if.sv
// CPU register-bus bundle for the jt900h interrupt controller.
interface jt900h_intc_if;
  logic        cs;
  logic [3:0]  addr;
  logic [15:0] din;
  logic [1:0]  we;
  logic [15:0] dout;

  modport master (output cs, addr, din, we, input dout);
  modport slave  (input cs, addr, din, we, output dout);
endinterface

// File: rtl/jt900h_intc.sv
// jt900h interrupt controller: NSRC sources, per-source priority and
// edge/level mode, registered highest-priority request and vector.
// Build option: define JT900H_INTC_NMI_EN to hardwire source 0 as a
// priority-7 edge source (NMI-like).
module jt900h_intc #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic [NSRC-1:0] src,
  jt900h_intc_if.slave    bus,
  input  logic            irq_ack,
  output logic [2:0]      intrq,
  output logic [3:0]      vec
);
`ifdef JT900H_INTC_NMI_EN
  localparam bit NMI = 1'b1;
`else
  localparam bit NMI = 1'b0;
`endif

  logic [NSRC-1:0]       s1_q, s2_q, s3_q;
  logic [NSRC-1:0][2:0]  prio_q;
  logic [NSRC-1:0]       mode_q, pend_q, pend_d;
  logic [NSRC-1:0]       hit, w1c, ack, rise;
  logic [2:0]            intrq_q, arb_p;
  logic [3:0]            vec_q, arb_v;
  logic [15:0]           dout_q, rd_d;
  logic                  unused_bits;

  // high byte carries no fields; only its enable is decoded away
  assign unused_bits = ^{bus.din[15:8], bus.din[6:4], bus.we[1]};

  // two-stage synchroniser plus a third stage used only for edge detection
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (cen) begin
      s1_q <= src;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end

  for (genvar k = 0; k < NSRC; k++) begin : g_dec
    assign hit[k] = bus.cs && bus.we[0] && (bus.addr == 4'(k));
    assign ack[k] = irq_ack && (vec_q == 4'(k));
  end
  assign w1c  = hit & {NSRC{bus.din[7]}};
  assign rise = s2_q & ~s3_q;

  // edge sources: a new edge beats any clear; level sources track the input
  always_comb begin
    pend_d = (mode_q & (rise | (pend_q & ~(w1c | ack)))) | (~mode_q & s2_q);
  end

  // pending flags
  always_ff @(posedge clk or negedge rst)
    if (!rst)     pend_q <= '0;
    else if (cen) pend_q <= pend_d;

  // per-source configuration; source 0 is fixed when built as an NMI
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int k = 0; k < NSRC; k++) begin
        prio_q[k] <= (NMI && k == 0) ? 3'd7 : 3'd0;
        mode_q[k] <= NMI && k == 0;
      end
    end else if (cen) begin
      for (int k = 0; k < NSRC; k++)
        if (hit[k] && !(NMI && k == 0)) begin
          prio_q[k] <= bus.din[2:0];
          mode_q[k] <= bus.din[3];
        end
    end

  // strict '>' over ascending index keeps the lowest index on ties
  always_comb begin
    arb_p = 3'd0;
    arb_v = 4'hF;
    for (int i = 0; i < NSRC; i++)
      if (pend_q[i] && prio_q[i] > arb_p) begin
        arb_p = prio_q[i];
        arb_v = 4'(i);
      end
  end

  // registered request outputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      intrq_q <= 3'd0;
      vec_q   <= 4'hF;
    end else if (cen) begin
      intrq_q <= arb_p;
      vec_q   <= arb_v;
    end

  // read mux over current (pre-update) state
  always_comb begin
    rd_d = 16'h0000;
    if (bus.addr == 4'hF)
      rd_d = {4'h0, vec_q, 5'b00000, intrq_q};
    else
      for (int k = 0; k < NSRC; k++)
        if (bus.addr == 4'(k))
          rd_d = {8'h00, pend_q[k], 3'b000, mode_q[k], prio_q[k]};
  end

  // read data holds until the next read cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst)                                dout_q <= 16'h0000;
    else if (cen && bus.cs && bus.we == 2'b00) dout_q <= rd_d;

  assign bus.dout = dout_q;
  assign intrq    = intrq_q;
  assign vec      = vec_q;
endmodule
